// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbitrated mux: the select-width helper
// and the values every register takes on reset.
package rr_arb_pkg;

   // Ceiling log2, used to size channel indices (value >= 2 in practice)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam logic        RST_OUT_VALID = 1'b0;
   localparam int unsigned RST_PTR       = 0;
   localparam int unsigned RST_CHAN      = 0;
   localparam int unsigned RST_COUNT     = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder. Scans req starting at ptr, wrapping from
// N-1 to 0, and reports the first requesting channel.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N);

   // req concatenated with itself (top copy trimmed to what a rotation can reach),
   // so a rotation by ptr becomes a plain window of N bits.
   logic [2*N-2:0]   w_req2;
   logic [N-1:0]     w_rot;
   logic [SEL_W-1:0] w_off;
   logic [SEL_W:0]   w_sum;

   assign w_req2 = {req[N-2:0], req};

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_rot
         assign w_rot[gi] = w_req2[{1'b0, ptr} + (SEL_W+1)'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated request is the offset of the winner from ptr
   always_comb begin
      w_off   = '0;
      gnt_any = 1'b0;
      for (int k = N-1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off   = SEL_W'(k);
            gnt_any = 1'b1;
         end
      end
   end

   // Map the offset back to an absolute channel index modulo N
   always_comb begin
      w_sum   = {1'b0, ptr} + {1'b0, w_off};
      gnt_idx = w_sum[SEL_W-1:0];
      if (w_sum >= N_W) begin
         gnt_idx = SEL_W'(w_sum - N_W);
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrated word selector with a single registered output stage
// (valid/ready both sides, 1-cycle latency, full throughput).
// Optional feature macro ARB_MUX_STATS_EN adds saturating per-channel grant counters
// on the grant_count port.
module rr_arb_mux
   import rr_arb_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 32,
   parameter  int CNT_W = 16,
   localparam int SEL_W = clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_chan,
   output logic               out_valid,
   input  logic               out_ready
`ifdef ARB_MUX_STATS_EN
   ,
   output logic [N*CNT_W-1:0] grant_count
`endif
);

   logic [WIDTH-1:0] w_chan_data [N];
   logic [SEL_W-1:0] w_gnt_idx;
   logic             w_req_any;
   logic             w_slot_free;
   logic             w_grant;
   logic [SEL_W-1:0] w_ptr_next;

   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_chan;
   logic             r_out_valid;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   rr_pick #(
      .N (N)
   ) u_pick (
      .req     (in_valid),
      .ptr     (r_ptr),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_req_any)
   );

   // The output register can take a word when empty or being drained this cycle.
   // Reset is folded in so no source sees a ready while reset is held.
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_grant     = w_slot_free && w_req_any && !reset;
   assign w_ptr_next  = (w_gnt_idx == SEL_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = w_grant && (w_gnt_idx == SEL_W'(gi));
      end
   endgenerate

   // Output register and round-robin pointer: load on grant, empty on a bare pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= RST_OUT_VALID;
         r_out_data  <= '0;
         r_out_chan  <= SEL_W'(RST_CHAN);
         r_ptr       <= SEL_W'(RST_PTR);
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_chan_data[w_gnt_idx];
         r_out_chan  <= w_gnt_idx;
         r_ptr       <= w_ptr_next;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_valid = r_out_valid;

`ifdef ARB_MUX_STATS_EN
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_stats
         logic [CNT_W-1:0] r_count;

         // Count accepted words per channel, sticking at all-ones
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_count <= CNT_W'(RST_COUNT);
            end else if (in_ready[gi] && (r_count != {CNT_W{1'b1}})) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign grant_count[gi*CNT_W +: CNT_W] = r_count;
      end
   endgenerate
`else
   // Counter width only matters when statistics are built in
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed scoreboard bench for rr_arb_mux (N=4, WIDTH=32, CNT_W=2).
module tb_rr_arb_mux;

   localparam int N     = 4;
   localparam int WIDTH = 32;
   localparam int CNT_W = 2;

   typedef struct packed {
      logic [1:0]  chan;
      logic [31:0] data;
   } exp_t;

   logic               clk;
   logic               reset;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_chan;
   logic               out_valid;
   logic               out_ready;
`ifdef ARB_MUX_STATS_EN
   logic [N*CNT_W-1:0] grant_count;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   rr_arb_mux #(
      .N     (N),
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ARB_MUX_STATS_EN
      ,
      .grant_count (grant_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] std_data(input int ch);
      return 32'hA0A0_0000 | 32'(ch);
   endfunction

   task automatic load_std_data();
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = std_data(i);
   endtask

   task automatic push(input int ch, input logic [31:0] d);
      exp_t e;
      e.chan = 2'(ch);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every output transfer (completes at the next rising edge) pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pop: got chan %0d data %h expected no transfer", out_chan, out_data);
         end else begin
            e = exp_q.pop_front();
            $display("pop chan=%0d data=%h (exp chan=%0d data=%h)", out_chan, out_data, e.chan, e.data);
            chk("pop_chan", 64'(out_chan), 64'(e.chan));
            chk("pop_data", 64'(out_data), 64'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_ch;
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      // No grant may be visible while reset is held, even with requests present
      in_valid = 4'b1111;
      #1;
      chk("ready_in_reset", 64'(in_ready), 64'(0));
      in_valid = '0;
      tick();
      reset = 1'b0;
      tick();

      // 1: idle after reset
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_chan", 64'(out_chan), 64'(0));
`ifdef ARB_MUX_STATS_EN
      chk("rst_counts", 64'(grant_count), 64'(0));
`endif

      // 2: single requester ch2
      in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      chk("t2_in_ready", 64'(in_ready), 64'b0100);
      push(2, 32'hDEADBEEF);
      $display("issue t2 ch=2 data=deadbeef");
      tick();
      in_valid = '0;
      chk("t2_out_valid", 64'(out_valid), 64'(1));
      chk("t2_out_data", 64'(out_data), 64'hDEADBEEF);
      chk("t2_out_chan", 64'(out_chan), 64'(2));
      tick();
      chk("t2_drained", 64'(out_valid), 64'(0));
      chk("t2_hold_data", 64'(out_data), 64'hDEADBEEF);

      // 3: all valid, ptr starts at 3 -> 3,0,1,2,3,0,1,2 with no bubbles
      load_std_data();
      in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         exp_ch = (3 + i) % N;
         #1;
         chk("t3_in_ready", 64'(in_ready), 64'(1) << exp_ch);
         push(exp_ch, std_data(exp_ch));
         $display("issue t3 ch=%0d data=%h", exp_ch, std_data(exp_ch));
         tick();
         chk("t3_no_bubble", 64'(out_valid), 64'(1));
         chk("t3_out_chan", 64'(out_chan), 64'(exp_ch));
      end
      in_valid = '0;
      tick();
      chk("t3_drained", 64'(out_valid), 64'(0));

      // 4: stall with all valid, ptr=3
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      #1;
      chk("t4_first_grant", 64'(in_ready), 64'b1000);
      push(3, std_data(3));
      $display("issue t4 ch=3 data=%h", std_data(3));
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_ready", 64'(in_ready), 64'(0));
         chk("t4_stall_data", 64'(out_data), 64'(std_data(3)));
         chk("t4_stall_chan", 64'(out_chan), 64'(3));
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t4_release_ready", 64'(in_ready), 64'b0001);
      push(0, std_data(0));
      $display("issue t4 ch=0 data=%h", std_data(0));
      tick();
      in_valid = '0;
      chk("t4_b2b_valid", 64'(out_valid), 64'(1));
      chk("t4_b2b_chan", 64'(out_chan), 64'(0));
      tick();

      // 5: ptr=1, ch3 alone then ch0+ch3 -> wrap makes ch0 win
      in_valid = 4'b1000;
      #1;
      chk("t5_ch3_ready", 64'(in_ready), 64'b1000);
      push(3, std_data(3));
      $display("issue t5 ch=3 data=%h", std_data(3));
      tick();
      in_valid = 4'b1001;
      #1;
      chk("t5_wrap_ready", 64'(in_ready), 64'b0001);
      push(0, std_data(0));
      $display("issue t5 ch=0 data=%h", std_data(0));
      tick();
      in_valid = '0;
      tick();
      chk("t5_drained", 64'(out_valid), 64'(0));

      // 6: fresh reset, then five grants to ch1
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t6_in_ready", 64'(in_ready), 64'b0010);
         push(1, std_data(1));
         $display("issue t6 ch=1 data=%h", std_data(1));
         tick();
`ifdef ARB_MUX_STATS_EN
         if (i == 1) chk("t6_count_2", 64'(grant_count), 64'(2) << CNT_W);
`endif
      end
`ifdef ARB_MUX_STATS_EN
      chk("t6_count_sat", 64'(grant_count), 64'(3) << CNT_W);
`endif
      in_valid = '0;
      tick();

      // Reset while a word is held: dropped immediately
      out_ready = 1'b0;
      in_valid  = 4'b0001;
      tick();
      chk("hold_valid", 64'(out_valid), 64'(1));
      in_valid = 4'b1111;
      reset    = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_data", 64'(out_data), 64'(0));
      chk("mid_rst_ready", 64'(in_ready), 64'(0));
`ifdef ARB_MUX_STATS_EN
      chk("mid_rst_counts", 64'(grant_count), 64'(0));
`endif
      tick();
      reset     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("final_idle", 64'(out_valid), 64'(0));
      chk("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
